// File: rtl/ahb_lite_initiator_if.sv
// Signal bundle for ahb_lite_initiator: command/response side plus the AHB-Lite bus.
// master is the initiator's view; slave is the environment (command source and AHB slave).
interface ahb_lite_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_abort;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_abort,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_abort,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_lite_initiator.sv
// Two-stage (address/data phase) AHB-Lite single-transfer initiator with in-order responses.
// Optional macro AHB_INIT_ALIGN_CHECK_EN: misaligned halfword/word commands are aborted instead of issued.
module ahb_lite_initiator (
  input  logic                 sim_clock,
  input  logic                 power_on_reset_n,
  ahb_lite_initiator_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ERR_OK,
    ERR_ONE,
    ERR_TWO
  } err_state_t;

  err_state_t err_state_reg, err_state_next;

  // Address-phase slot; an aborted entry rides the pipeline for ordering but never shows NONSEQ.
  logic        ap_valid_reg, ap_valid_next;
  logic        ap_abort_reg, ap_abort_next;
  logic [31:0] ap_addr_reg,  ap_addr_next;
  logic        ap_write_reg, ap_write_next;
  logic [2:0]  ap_size_reg,  ap_size_next;
  logic [31:0] ap_wdata_reg, ap_wdata_next;

  logic        dp_valid_reg, dp_valid_next;
  logic        dp_abort_reg, dp_abort_next;
  logic        dp_write_reg, dp_write_next;
  logic [31:0] dp_wdata_reg, dp_wdata_next;

  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic        rsp_err_reg,   rsp_err_next;
  logic        rsp_abort_reg, rsp_abort_next;

  logic        cmd_ready;
  logic        cmd_accept;
  logic        cmd_illegal;
  logic        cmd_misaligned;
  logic        cmd_reject;
  logic        ap_advance;
  logic        dp_on_bus;
  logic        dp_done;
  logic        dp_drive_wdata;
  logic [31:0] hwdata;

  assign cmd_ready   = (!ap_valid_reg || bus.HREADY) && (err_state_reg != ERR_TWO);
  assign cmd_accept  = bus.cmd_valid && cmd_ready;
  assign cmd_illegal = (bus.cmd_size > 3'd2);

`ifdef AHB_INIT_ALIGN_CHECK_EN
  assign cmd_misaligned = ((bus.cmd_size == 3'd1) && bus.cmd_addr[0]) ||
                          ((bus.cmd_size == 3'd2) && (bus.cmd_addr[1:0] != 2'b00));
`else
  assign cmd_misaligned = 1'b0;
`endif

  assign cmd_reject = cmd_illegal || cmd_misaligned;

  // An aborted data-phase entry is not on the bus, so it retires without waiting for HREADY.
  assign dp_on_bus      = dp_valid_reg && !dp_abort_reg;
  assign dp_done        = dp_valid_reg && (dp_abort_reg || bus.HREADY);
  assign ap_advance     = ap_valid_reg && bus.HREADY;
  assign dp_drive_wdata = dp_on_bus && dp_write_reg;

  always_comb begin
    err_state_next = err_state_reg;
    case (err_state_reg)
      ERR_OK: begin
        if (dp_on_bus && bus.HRESP && !bus.HREADY) begin
          err_state_next = ERR_ONE;
        end
      end
      // Leave on any HREADY so a malformed second error cycle cannot wedge the pipeline.
      ERR_ONE: begin
        if (bus.HREADY) begin
          err_state_next = ERR_TWO;
        end
      end
      ERR_TWO: begin
        err_state_next = ERR_OK;
      end
      default: begin
        err_state_next = ERR_OK;
      end
    endcase
  end

  always_comb begin
    ap_valid_next = ap_valid_reg;
    ap_abort_next = ap_abort_reg;
    ap_addr_next  = ap_addr_reg;
    ap_write_next = ap_write_reg;
    ap_size_next  = ap_size_reg;
    ap_wdata_next = ap_wdata_reg;

    if (ap_advance) begin
      ap_valid_next = 1'b0;
    end
    if (cmd_accept) begin
      ap_valid_next = 1'b1;
      ap_abort_next = cmd_reject;
      // Rejected commands leave the address-phase fields untouched so they never reach HSIZE/HADDR.
      if (!cmd_reject) begin
        ap_addr_next  = bus.cmd_addr;
        ap_write_next = bus.cmd_write;
        ap_size_next  = bus.cmd_size;
        ap_wdata_next = bus.cmd_wdata;
      end
    end
    if (err_state_next == ERR_ONE) begin
      ap_abort_next = 1'b1;
    end
  end

  always_comb begin
    dp_valid_next = dp_valid_reg;
    dp_abort_next = dp_abort_reg;
    dp_write_next = dp_write_reg;
    dp_wdata_next = dp_wdata_reg;

    if (dp_done) begin
      dp_valid_next = 1'b0;
    end
    if (ap_advance) begin
      dp_valid_next = 1'b1;
      dp_abort_next = ap_abort_reg;
      dp_write_next = ap_write_reg;
      dp_wdata_next = ap_wdata_reg;
    end
  end

  always_comb begin
    rsp_valid_next = dp_done;
    rsp_err_next   = 1'b0;
    rsp_abort_next = 1'b0;
    rsp_rdata_next = 32'h0;
    if (dp_done) begin
      rsp_abort_next = dp_abort_reg;
      rsp_err_next   = dp_abort_reg || bus.HRESP || (err_state_reg == ERR_ONE);
      if (!dp_abort_reg && !dp_write_reg && !bus.HRESP) begin
        rsp_rdata_next = bus.HRDATA;
      end
    end
  end

  always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      err_state_reg <= ERR_OK;
      ap_valid_reg  <= 1'b0;
      ap_abort_reg  <= 1'b0;
      ap_addr_reg   <= 32'h0;
      ap_write_reg  <= 1'b0;
      ap_size_reg   <= 3'd0;
      ap_wdata_reg  <= 32'h0;
      dp_valid_reg  <= 1'b0;
      dp_abort_reg  <= 1'b0;
      dp_write_reg  <= 1'b0;
      dp_wdata_reg  <= 32'h0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
      rsp_abort_reg <= 1'b0;
    end else begin
      err_state_reg <= err_state_next;
      ap_valid_reg  <= ap_valid_next;
      ap_abort_reg  <= ap_abort_next;
      ap_addr_reg   <= ap_addr_next;
      ap_write_reg  <= ap_write_next;
      ap_size_reg   <= ap_size_next;
      ap_wdata_reg  <= ap_wdata_next;
      dp_valid_reg  <= dp_valid_next;
      dp_abort_reg  <= dp_abort_next;
      dp_write_reg  <= dp_write_next;
      dp_wdata_reg  <= dp_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_abort_reg <= rsp_abort_next;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_hwdata_lane
    assign hwdata[gi*8 +: 8] = dp_drive_wdata ? dp_wdata_reg[gi*8 +: 8] : 8'h00;
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_abort = rsp_abort_reg;

  assign bus.HTRANS    = (ap_valid_reg && !ap_abort_reg) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = ap_addr_reg;
  assign bus.HWRITE    = ap_write_reg;
  assign bus.HSIZE     = ap_size_reg;
  assign bus.HWDATA    = hwdata;
  assign bus.HBURST    = 3'b000;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = 4'b0011;

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Directed bench for ahb_lite_initiator: hand-computed bus and response expectations per cycle.
module tb_ahb_lite_initiator;

  logic sim_clock;
  logic power_on_reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   c0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        abort;
  } rsp_t;

  rsp_t rsp_q[$];

  ahb_lite_initiator_if bus ();

  ahb_lite_initiator dut (
    .sim_clock        (sim_clock),
    .power_on_reset_n (power_on_reset_n),
    .bus              (bus)
  );

  initial sim_clock = 1'b0;
  always #5 sim_clock = ~sim_clock;

  initial cyc = 0;
  always @(posedge sim_clock) cyc <= cyc + 1;

  always @(negedge sim_clock) begin
    if (bus.rsp_valid === 1'b1) begin
      rsp_q.push_back('{cyc: cyc, rdata: bus.rsp_rdata, err: bus.rsp_err, abort: bus.rsp_abort});
      $display("rsp cyc=%0d rdata=%08h err=%0b abort=%0b", cyc, bus.rsp_rdata, bus.rsp_err, bus.rsp_abort);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge sim_clock);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask

  task automatic set_slave(input logic rdy, input logic resp, input logic [31:0] rdata);
    bus.HREADY = rdy;
    bus.HRESP  = resp;
    bus.HRDATA = rdata;
  endtask

  task automatic expect_rsp(input string tag, input int exp_cyc, input logic [31:0] rdata,
                            input logic err, input logic abort);
    rsp_t r;
    check({tag, "_present"}, 32'(rsp_q.size() != 0), 32'd1);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      check({tag, "_cyc"}, 32'(r.cyc), 32'(exp_cyc));
      check({tag, "_rdata"}, r.rdata, rdata);
      check({tag, "_err_abort"}, 32'({r.err, r.abort}), 32'({err, abort}));
    end
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_no_extra_rsp"}, 32'(rsp_q.size()), 32'd0);
    rsp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    power_on_reset_n = 1'b0;
    set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    set_slave(1'b1, 1'b0, 32'h0);

    // Reset values and tie-offs
    next_cycle; #1;
    check("rst_htrans",    32'(bus.HTRANS),    32'd0);
    check("rst_haddr",     bus.HADDR,          32'h0);
    check("rst_hwrite",    32'(bus.HWRITE),    32'd0);
    check("rst_hsize",     32'(bus.HSIZE),     32'd0);
    check("rst_hwdata",    bus.HWDATA,         32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_rsp_abort", 32'(bus.rsp_abort), 32'd0);
    check("hburst",        32'(bus.HBURST),    32'd0);
    check("hmastlock",     32'(bus.HMASTLOCK), 32'd0);
    check("hprot",         32'(bus.HPROT),     32'h3);
    next_cycle;
    power_on_reset_n = 1'b1;
    next_cycle;
    next_cycle;

    // Write then read, zero wait
    next_cycle; set_cmd(1'b1, 1'b1, 32'h2000_0000, 3'd2, 32'hDEAD_BEEF); c0 = cyc; #1;
    check("s1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    next_cycle; set_cmd(1'b1, 1'b0, 32'h2000_0000, 3'd2, 32'h0); #1;
    check("s1_wr_htrans", 32'(bus.HTRANS), 32'd2);
    check("s1_wr_haddr",  bus.HADDR,       32'h2000_0000);
    check("s1_wr_hwrite", 32'(bus.HWRITE), 32'd1);
    check("s1_wr_hsize",  32'(bus.HSIZE),  32'd2);
    next_cycle; set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); #1;
    check("s1_wr_hwdata", bus.HWDATA,      32'hDEAD_BEEF);
    check("s1_rd_htrans", 32'(bus.HTRANS), 32'd2);
    check("s1_rd_hwrite", 32'(bus.HWRITE), 32'd0);
    next_cycle; set_slave(1'b1, 1'b0, 32'hDEAD_BEEF); #1;
    check("s1_idle_htrans", 32'(bus.HTRANS), 32'd0);
    check("s1_rd_hwdata",   bus.HWDATA,      32'h0);
    next_cycle; set_slave(1'b1, 1'b0, 32'h0);
    next_cycle;
    expect_rsp("s1_wr", c0 + 3, 32'h0, 1'b0, 1'b0);
    expect_rsp("s1_rd", c0 + 4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    expect_empty("s1");

    // Eight back-to-back reads
    for (int k = 0; k < 11; k++) begin
      next_cycle;
      if (k == 0) c0 = cyc;
      if (k < 8) set_cmd(1'b1, 1'b0, 32'h1000 + 32'(4 * k), 3'd2, 32'h0);
      else       set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      set_slave(1'b1, 1'b0, (k >= 2) ? 32'hA500_0000 + 32'(k - 2) : 32'h0);
      #1;
      if (k >= 1 && k <= 8) begin
        check($sformatf("s2_htrans%0d", k - 1), 32'(bus.HTRANS), 32'd2);
        check($sformatf("s2_haddr%0d", k - 1),  bus.HADDR, 32'h1000 + 32'(4 * (k - 1)));
      end
    end
    next_cycle; set_slave(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      expect_rsp($sformatf("s2_rd%0d", i), c0 + 3 + i, 32'hA500_0000 + 32'(i), 1'b0, 1'b0);
    end
    expect_empty("s2");

    // Three wait states in a write data phase, read waiting in the address phase
    next_cycle; set_cmd(1'b1, 1'b1, 32'h3000_0010, 3'd2, 32'h1234_5678); c0 = cyc; #1;
    next_cycle; set_cmd(1'b1, 1'b0, 32'h3000_0020, 3'd2, 32'h0); #1;
    check("s3_wr_haddr", bus.HADDR, 32'h3000_0010);
    for (int w = 0; w < 3; w++) begin
      next_cycle; set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); set_slave(1'b0, 1'b0, 32'h0); #1;
      check($sformatf("s3_wait%0d_haddr", w),  bus.HADDR,          32'h3000_0020);
      check($sformatf("s3_wait%0d_htrans", w), 32'(bus.HTRANS),    32'd2);
      check($sformatf("s3_wait%0d_hwdata", w), bus.HWDATA,         32'h1234_5678);
      check($sformatf("s3_wait%0d_ready", w),  32'(bus.cmd_ready), 32'd0);
    end
    next_cycle; set_slave(1'b1, 1'b0, 32'h0); #1;
    check("s3_done_hwdata", bus.HWDATA, 32'h1234_5678);
    next_cycle; set_slave(1'b1, 1'b0, 32'h0BAD_F00D); #1;
    next_cycle; set_slave(1'b1, 1'b0, 32'h0);
    next_cycle;
    expect_rsp("s3_wr", c0 + 6, 32'h0, 1'b0, 1'b0);
    expect_rsp("s3_rd", c0 + 7, 32'h0BAD_F00D, 1'b0, 1'b0);
    expect_empty("s3");

    // Two-cycle ERROR response with a read pending in the address phase
    next_cycle; set_cmd(1'b1, 1'b0, 32'h4000_0004, 3'd2, 32'h0); c0 = cyc; #1;
    next_cycle; set_cmd(1'b1, 1'b0, 32'h4000_0008, 3'd2, 32'h0); #1;
    check("s4_haddr", bus.HADDR, 32'h4000_0004);
    next_cycle; set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); set_slave(1'b0, 1'b1, 32'h0); #1;
    check("s4_err1_ready", 32'(bus.cmd_ready), 32'd0);
    next_cycle; set_slave(1'b1, 1'b1, 32'h0); #1;
    check("s4_err2_htrans", 32'(bus.HTRANS), 32'd0);
    next_cycle; set_slave(1'b1, 1'b0, 32'h0); #1;
    check("s4_recover_ready_low", 32'(bus.cmd_ready), 32'd0);
    next_cycle; #1;
    check("s4_ready_back", 32'(bus.cmd_ready), 32'd1);
    next_cycle;
    expect_rsp("s4_err",   c0 + 4, 32'h0, 1'b1, 1'b0);
    expect_rsp("s4_abort", c0 + 5, 32'h0, 1'b1, 1'b1);
    expect_empty("s4");

    // HRESP with HREADY in one cycle, followed by an illegal size
    next_cycle; set_cmd(1'b1, 1'b0, 32'h4000_0010, 3'd2, 32'h0); c0 = cyc; #1;
    next_cycle; set_cmd(1'b1, 1'b0, 32'h5000_0000, 3'd3, 32'h0); #1;
    check("s5_rd_htrans", 32'(bus.HTRANS), 32'd2);
    next_cycle; set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); set_slave(1'b1, 1'b1, 32'h0); #1;
    check("s5_illegal_htrans", 32'(bus.HTRANS), 32'd0);
    check("s5_illegal_hsize",  32'(bus.HSIZE),  32'd2);
    next_cycle; set_slave(1'b1, 1'b0, 32'h0); #1;
    check("s5_ready", 32'(bus.cmd_ready), 32'd1);
    next_cycle;
    next_cycle;
    expect_rsp("s5_violation", c0 + 3, 32'h0, 1'b1, 1'b0);
    expect_rsp("s5_illegal",   c0 + 4, 32'h0, 1'b1, 1'b1);
    expect_empty("s5");

    // Misaligned word
    next_cycle; set_cmd(1'b1, 1'b0, 32'h2000_0002, 3'd2, 32'h0); c0 = cyc; #1;
    next_cycle; set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); #1;
`ifdef AHB_INIT_ALIGN_CHECK_EN
    check("s6_htrans", 32'(bus.HTRANS), 32'd0);
`else
    check("s6_htrans", 32'(bus.HTRANS), 32'd2);
    check("s6_haddr",  bus.HADDR,       32'h2000_0002);
`endif
    next_cycle; set_slave(1'b1, 1'b0, 32'h0000_0077); #1;
    next_cycle; set_slave(1'b1, 1'b0, 32'h0);
    next_cycle;
`ifdef AHB_INIT_ALIGN_CHECK_EN
    expect_rsp("s6_misaligned", c0 + 3, 32'h0, 1'b1, 1'b1);
`else
    expect_rsp("s6_misaligned", c0 + 3, 32'h0000_0077, 1'b0, 1'b0);
`endif
    expect_empty("s6");

    // Reset during a wait-stated transfer
    next_cycle; set_cmd(1'b1, 1'b0, 32'h6000_0000, 3'd2, 32'h0); #1;
    next_cycle; set_cmd(1'b1, 1'b0, 32'h6000_0004, 3'd2, 32'h0); #1;
    next_cycle; set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); set_slave(1'b0, 1'b0, 32'h0); #1;
    check("s7_pre_htrans", 32'(bus.HTRANS), 32'd2);
    #1;
    power_on_reset_n = 1'b0;
    #1;
    check("s7_rst_htrans",    32'(bus.HTRANS),    32'd0);
    check("s7_rst_haddr",     bus.HADDR,          32'h0);
    check("s7_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    next_cycle;
    next_cycle;
    power_on_reset_n = 1'b1;
    set_slave(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      next_cycle;
    end
    expect_empty("s7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_initiator.md
AHB_LITE_INITIATOR -- requirements
Module: ahb_lite_initiator

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- sim_clock  input  1  bus clock; all state on rising edge.
- power_on_reset_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready both high.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  32  byte address.
- cmd_size  input  3  0=byte, 1=halfword, 2=word; 3..7 illegal.
- cmd_wdata  input  32  write data, already lane-aligned by caller.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_err  output  1  slave ERROR, or command cancelled.
- rsp_abort  output  1  command cancelled; never issued on the bus.
- HADDR  output  32  AHB-Lite address.
- HTRANS  output  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  output  1  transfer direction.
- HSIZE  output  3  transfer size.
- HBURST  output  3  constant 000 (SINGLE).
- HMASTLOCK  output  1  constant 0.
- HPROT  output  4  constant 0011.
- HWDATA  output  32  write data.
- HRDATA  input  32  read data.
- HREADY  input  1  transfer complete.
- HRESP  input  1  error response.

Function
REQ-002 SHALL provide a two-stage pipeline: an address-phase register (AP) and a data-phase register (DP); the address phase of transfer N+1 SHALL overlap the data phase of transfer N.
REQ-003 cmd_ready SHALL be (AP empty or HREADY) and not in ERR2 state (REQ-009); it is combinational.
REQ-004 An accepted command SHALL load AP; HTRANS SHALL be NONSEQ while AP is valid and IDLE otherwise; HADDR, HWRITE and HSIZE SHALL come from AP.
REQ-005 AP SHALL move to DP on a rising edge with HREADY high; with HREADY low, AP and all address-phase outputs SHALL hold.
REQ-006 HWDATA SHALL be driven from DP write data throughout a write data phase and held until HREADY; HWDATA SHALL be 0 otherwise.
REQ-007 A data phase completing with HREADY=1 and HRESP=0 SHALL produce rsp_valid=1 on the next cycle, with rsp_rdata=HRDATA (reads) or 0 (writes), and rsp_err=0.
REQ-008 Zero-wait back-to-back commands SHALL sustain one transfer per cycle; latency from acceptance to rsp_valid SHALL be 3 cycles with zero wait states.
REQ-009 State machine for errors: OK -> ERR1 on HRESP=1 with HREADY=0; ERR1 -> ERR2 on HRESP=1 with HREADY=1; ERR2 -> OK after one cycle.
- On entering ERR1, HTRANS SHALL be driven IDLE and a pending AP SHALL be cancelled.
- The erroring transfer SHALL respond with rsp_err=1 and rsp_abort=0.
- The cancelled command SHALL respond on the following cycle with rsp_err=1 and rsp_abort=1.
REQ-010 HRESP=1 together with HREADY=1 while in OK SHALL be treated as a protocol violation: the transfer responds rsp_err=1, and the pipeline continues.
REQ-011 Responses SHALL be in command order; rsp has no backpressure.
REQ-012 cmd_size values 3..7 SHALL never reach the bus: the command responds rsp_err=1 and rsp_abort=1, in order.

Reset
REQ-013 Asserting power_on_reset_n low SHALL, asynchronously, clear AP, DP and the error state to OK.
REQ-014 Reset values SHALL be: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_abort=0.
REQ-015 Reset mid-transfer SHALL drop all in-flight commands with no responses.

Configuration
REQ-016 With macro AHB_INIT_ALIGN_CHECK_EN defined, halfword commands with addr[0]=1 and word commands with addr[1:0]!=0 SHALL not be issued; they respond rsp_err=1 and rsp_abort=1, in order.
REQ-017 With AHB_INIT_ALIGN_CHECK_EN undefined, such commands SHALL be issued unchanged.

Verification
REQ-018 Bench SHALL cover:
- Write 0x20000000 size 2 data 0xDEADBEEF, then read 0x20000000, zero wait -> HWDATA=0xDEADBEEF during write data phase; read rsp_rdata=0xDEADBEEF; rsp_err=0.
- 8 back-to-back reads, HREADY=1 -> 8 NONSEQ in 8 consecutive cycles; 8 in-order responses.
- HREADY low 3 cycles during a write data phase -> HADDR, HTRANS and HWDATA stable; cmd_ready=0; single response.
- HRESP two-cycle error on read 0x40000004 with a read pending in AP -> HTRANS=IDLE in 2nd error cycle; responses (err=1, abort=0) then (err=1, abort=1).
- Word command at 0x20000002 -> with AHB_INIT_ALIGN_CHECK_EN: no NONSEQ, err=1, abort=1; without it: NONSEQ issued.
- Reset asserted during a wait-stated transfer -> HTRANS=00 immediately; no rsp_valid after release.
